// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the control unit.
// Owns the program counter, reads instruction memory over a req/ready
// handshake and presents one fetched word plus its PC in a single-entry
// output register that downstream back-pressures with stall.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   stall               downstream not ready; output register holds
//   redirect            apply the jump_sel target at this edge (flushes)
//   jump_sel            0: pc_out+4, 1: pc_out+(jump_offset<<2),
//                       2: jump_reg, 3: {pc_out[31:18], jump_field, 2'b00}
//   jump_offset         sign-extended word offset
//   jump_reg            register jump target
//   jump_field          absolute jump field
//   imem_req/imem_addr  word read request and word-aligned address
//   imem_ready          imem_rdata valid this cycle; completes the request
//   imem_rdata          read data
//   instruction/pc_out  presented instruction and its address (registered)
//   instr_valid         output register holds a valid entry
//   halted              halt opcode fetched; no further requests
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] jump_offset,
  input  logic [31:0] jump_reg,
  input  logic [15:0] jump_field,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic        halted
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_LSB = 26;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   instruction_q, instruction_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [XLEN-1:0]   target_raw;
  logic [XLEN-1:0]   target;
  logic              consume;
  logic              capture;
  logic              is_halt;

  // Request only when fetching and the output slot is free (or draining now).
  assign imem_req  = !rst && (state_q == S_FETCH) && (!valid_q || !stall);
  assign imem_addr = {fetch_pc_q[XLEN-1:2], 2'b00};

  assign instruction = instruction_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

  assign consume = valid_q && !stall;
  // A ready coinciding with a redirect is dropped: the fetched word is stale.
  assign capture = imem_req && imem_ready && !redirect;
  assign is_halt = (imem_rdata[XLEN-1:OPC_LSB] == HALT_OPCODE);

  // Redirect target relative to the presented instruction's PC.
  always_comb begin
    target_raw = pc_out_q + 32'd4;
    unique case (jump_sel)
      2'd0: target_raw = pc_out_q + 32'd4;
      2'd1: target_raw = pc_out_q + (jump_offset << 2);
      2'd2: target_raw = jump_reg;
      2'd3: target_raw = {pc_out_q[XLEN-1:18], jump_field, 2'b00};
      default: target_raw = pc_out_q + 32'd4;
    endcase
    target = {target_raw[XLEN-1:2], 2'b00};
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instruction_d = instruction_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    halted_d      = halted_q;

    if (redirect) begin
      fetch_pc_d = target;
      valid_d    = 1'b0;
      state_d    = S_FETCH;
      halted_d   = 1'b0;
    end else begin
      if (consume) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        S_FETCH: begin
          if (capture) begin
            instruction_d = imem_rdata;
            pc_out_d      = fetch_pc_q;
            valid_d       = 1'b1;
            if (is_halt) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
          end else if (valid_q && stall) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            state_d = S_FETCH;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_PC;
      instruction_q <= '0;
      pc_out_q      <= RESET_PC;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instruction_q <= instruction_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
    end
  end

endmodule
